cbi_sample_fifo_bank: RTL
=========================

// Module: cbi_sample_fifo_bank
// PURPOSE
//  Parametrised bank of NCH independent sample FIFOs. It replaces the fixed
//  2-channel, 16-deep ad-hoc FIFOs between the register interface and codec_if.
//  Each channel has full, empty and level outputs, programmable watermark
//  flags, sticky overflow/underflow flags, per-channel flush, and 32-bit
//  output formatting of DW-bit samples. One instance is used for RX and one
//  for TX inside the core.
// PARAMETERS
//  NCH    2   number of channels (1..8)
//  DEPTH  16  entries per channel; power of 2, >=4
//  DW     24  stored sample width (8..32)
//  AW     $clog2(DEPTH)  pointer width (localparam)
// PORTS
//  clk          in   1         clock; all logic on rising edge
//  rst          in   1         synchronous, active-high reset
//  en           in   NCH       per-channel enable; push ignored when 0
//  flush        in   NCH       per-channel pointer clear, one cycle
//  push         in   NCH       write strobe per channel
//  push_data    in   NCH*DW    channel c at [c*DW +: DW]
//  pop          in   NCH       read strobe per channel
//  pop_data     out  NCH*32    channel c at [c*32 +: 32], show-ahead
//  fmt_sext     in   1         1: sign-extend sample to 32b; 0: zero-extend
//  fmt_ljust    in   1         1: left-justify (sample in [31:32-DW], low bits 0); overrides sext
//  wm_hi        in   AW+1      almost-full threshold (shared by all channels)
//  wm_lo        in   AW+1      almost-empty threshold (shared by all channels)
//  full         out  NCH       level==DEPTH
//  empty        out  NCH       level==0
//  afull        out  NCH       level>=wm_hi
//  aempty       out  NCH       level<=wm_lo
//  level        out  NCH*(AW+1) occupancy per channel, 0..DEPTH
//  ovf          out  NCH       sticky: push dropped because full
//  unf          out  NCH       sticky: pop while empty
//  clr_ovf      in   NCH       clear ovf bit
//  clr_unf      in   NCH       clear unf bit
// BEHAVIOUR
//  - Reset: all pointers and levels are 0; empty=1, full=0, ovf=unf=0,
//    aempty=1 (wm_lo>=0), afull=(wm_hi==0). pop_data=0. Memory contents are
//    not reset.
//  - Pointers: head/tail are AW+1 bits (extra wrap bit).
//    full = (head^tail)=={1,0..0}; empty = head==tail.
//    level = head-tail, modulo 2^(AW+1). Wrap-around at DEPTH is seamless.
//  - Push (en[c]&push[c]):
//    - not full: mem[head]<=data; head+1.
//    - full with no pop in the same cycle: data dropped, head unchanged,
//      ovf[c]<=1.
//    - full with a simultaneous valid pop: both take effect, level stays DEPTH.
//  - Push with en[c]=0 is ignored silently; no ovf.
//  - Pop (pop[c]):
//    - not empty: tail+1.
//    - empty: tail unchanged, unf[c]<=1. A simultaneous push still writes,
//      because the data is not yet visible.
//  - pop is honoured regardless of en, so a disabled channel can still be drained.
//  - pop_data: combinational from mem[tail] plus format logic, 0 when empty;
//    the new head entry is visible the cycle after a pop. Write-to-read
//    latency is 1 cycle: a push at cycle N makes the entry visible and
//    empty=0 at N+1.
//  - Format, for sample s[DW-1:0]:
//    - ljust: {s,{32-DW{0}}}
//    - else if sext: {{32-DW{s[DW-1]}},s}
//    - else: {{32-DW{0}},s}
//    - DW==32 passes s through unchanged.
//  - Flags full/empty/afull/aempty/level are combinational from the
//    registered pointers, so they update 1 cycle after the causing strobe.
//  - Flush[c]: head=tail=0 next cycle. It has priority over push/pop in the
//    same cycle; those strobes are discarded with no ovf/unf. ovf/unf are
//    not touched by flush.
//  - Sticky flags: set has priority over clr in the same cycle; clr takes
//    effect otherwise. Only rst clears all flags.
//  - Channels are fully independent; simultaneous strobes on different
//    channels never interact.
//  - rst mid-operation: same as power-up reset. Any in-flight push/pop in the
//    reset cycle is discarded.
//  - wm_hi/wm_lo may change at any time; afull/aempty follow combinationally.
// TESTING
//  1 Reset, then 16 pushes ch0 (0x000001..0x000010), DEPTH=16 -> full[0]=1,
//    level=16, ch1 empty=1, ovf=0.
//  2 17th push ch0 while full -> ovf[0]=1, level 16; 16 pops return
//    0x000001..0x000010 in order, then empty.
//  3 Full ch0: push+pop same cycle -> level stays 16, no ovf; pop on empty
//    ch1 -> unf[1]=1, level 0; clr_unf[1] -> 0.
//  4 DW=24, push 0x800001: sext=1 -> 0xFF800001; sext=0 -> 0x00800001;
//    ljust=1 -> 0x80000100.
//  5 Push 40 samples while popping in bursts, wrapping pointers twice; set
//    wm_hi=12, wm_lo=3 -> afull asserted iff level>=12, aempty iff level<=3;
//    data order intact.
//  6 Level 7 on ch1, flush[1] with push[1] same cycle -> next cycle level 0,
//    empty, no ovf; ch0 level is unaffected.

Source files
------------

// File: rtl/cbi_sample_fifo_bank.sv
// Bank of NCH independent show-ahead sample FIFOs with level/watermark flags,
// sticky overflow/underflow, per-channel flush and 32-bit sample formatting.
module cbi_sample_fifo_bank #(
   parameter int NCH   = 2,
   parameter int DEPTH = 16,
   parameter int DW    = 24,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NCH-1:0]        en,
   input  logic [NCH-1:0]        flush,
   input  logic [NCH-1:0]        push,
   input  logic [NCH*DW-1:0]     push_data,
   input  logic [NCH-1:0]        pop,
   output logic [NCH*32-1:0]     pop_data,
   input  logic                  fmt_sext,
   input  logic                  fmt_ljust,
   input  logic [AW:0]           wm_hi,
   input  logic [AW:0]           wm_lo,
   output logic [NCH-1:0]        full,
   output logic [NCH-1:0]        empty,
   output logic [NCH-1:0]        afull,
   output logic [NCH-1:0]        aempty,
   output logic [NCH*(AW+1)-1:0] level,
   output logic [NCH-1:0]        ovf,
   output logic [NCH-1:0]        unf,
   input  logic [NCH-1:0]        clr_ovf,
   input  logic [NCH-1:0]        clr_unf
);

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      logic [AW:0]   head;
      logic [AW:0]   tail;
      logic [AW:0]   lvl;
      logic [DW-1:0] mem [DEPTH];
      logic          is_full;
      logic          is_empty;
      logic          push_req;
      logic          wr;
      logic          rd;
      logic          ovf_r;
      logic          unf_r;
      logic [DW-1:0] s;
      logic [31:0]   zx;
      logic [31:0]   sx;
      logic [31:0]   fmt;

      assign lvl      = head - tail;
      assign is_empty = (head == tail);
      assign is_full  = ((head ^ tail) == {1'b1, {AW{1'b0}}});

      // Flush discards both strobes of the cycle; pop does not depend on en.
      assign push_req = en[g] & push[g] & ~flush[g];
      assign rd       = pop[g] & ~flush[g] & ~is_empty;
      assign wr       = push_req & (~is_full | rd);

      always_ff @(posedge clk) begin
         if (rst) begin
            head  <= '0;
            tail  <= '0;
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
         end else begin
            if (flush[g]) begin
               head <= '0;
               tail <= '0;
            end else begin
               if (wr) head <= head + 1'b1;
               if (rd) tail <= tail + 1'b1;
            end
            ovf_r <= (push_req & is_full & ~rd) | (ovf_r & ~clr_ovf[g]);
            unf_r <= (pop[g] & ~flush[g] & is_empty) | (unf_r & ~clr_unf[g]);
         end
      end

      // When full with a pop, head and tail address the same slot; the read
      // is combinational this cycle so overwriting it at the edge is safe.
      always_ff @(posedge clk) begin
         if (!rst && wr) mem[head[AW-1:0]] <= push_data[g*DW +: DW];
      end

      assign s   = mem[tail[AW-1:0]];
      assign zx  = 32'(s);
      assign sx  = 32'($signed(s));
      assign fmt = fmt_ljust ? (zx << (32 - DW)) : (fmt_sext ? sx : zx);

      assign pop_data[g*32 +: 32]   = is_empty ? '0 : fmt;
      assign full[g]                = is_full;
      assign empty[g]               = is_empty;
      assign afull[g]               = (lvl >= wm_hi);
      assign aempty[g]              = (lvl <= wm_lo);
      assign level[g*(AW+1) +: AW+1] = lvl;
      assign ovf[g]                 = ovf_r;
      assign unf[g]                 = unf_r;
   end

endmodule
